// File: rtl/vram_port_arbiter_pkg.sv
// Shared types and default widths for the VRAM port arbiter: CPU
// handshake states and the tag recording who owned the RAM port last cycle.
package vram_port_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF   = 11;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int STARVE_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_ISSUED = 2'd1,
    C_DONE   = 2'd2,
    C_HOLD   = 2'd3
  } cpu_state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_VID  = 2'd1,
    G_CPU  = 2'd2
  } grant_t;

endpackage

// File: rtl/vram_starve_counter.sv
// Saturating count of cycles the CPU was blocked by video, with a sticky
// flag raised once the count hits all-ones.
module vram_starve_counter #(
  parameter int width_g = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam logic [width_g-1:0] max_c = {width_g{1'b1}};

  logic [width_g-1:0] count_q, count_d;
  logic               starved_q, starved_d;

  // next count and sticky flag
  always_comb begin
    count_d   = count_q;
    starved_d = starved_q;
    if (clr) begin
      count_d = {width_g{1'b0}};
    end else if (inc && (count_q != max_c)) begin
      count_d = count_q + width_g'(1);
    end else begin
      count_d = count_q;
    end
    if (count_d == max_c) begin
      starved_d = 1'b1;
    end else begin
      starved_d = starved_q;
    end
  end

  // counter and flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= {width_g{1'b0}};
      starved_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      starved_q <= starved_d;
    end
  end

  assign starved = starved_q;

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single VRAM port between the video scanner (absolute priority)
// and the CPU bus, which is served in free cycles through a wait/ack handshake.
module vram_port_arbiter
  import vram_port_arbiter_pkg::*;
#(
  parameter int addr_width_g   = ADDR_WIDTH_DEF,
  parameter int data_width_g   = DATA_WIDTH_DEF,
  parameter int starve_width_g = STARVE_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    vid_req,
  input  logic [addr_width_g-1:0] vid_addr,
  output logic                    vid_valid,
  output logic [data_width_g-1:0] vid_dout,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [addr_width_g-1:0] cpu_addr,
  input  logic [data_width_g-1:0] cpu_din,
  output logic [data_width_g-1:0] cpu_dout,
  output logic                    cpu_ack,
  output logic                    cpu_wait,
  output logic                    cpu_starved,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    ram_wren,
  input  logic [data_width_g-1:0] ram_q
);

  cpu_state_t              state_q, state_d;
  grant_t                  grant_q, grant_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic [data_width_g-1:0] cpu_dout_q, cpu_dout_d;
  logic                    issued_we_q, issued_we_d;
  logic                    cpu_grant_s;
  logic                    ram_wren_s;
  logic [addr_width_g-1:0] ram_address_s;
  logic                    blocked_s;

  // port mux, CPU handshake next state and read-data capture
  always_comb begin
    state_d       = state_q;
    grant_d       = G_NONE;
    cpu_ack_d     = 1'b0;
    cpu_dout_d    = cpu_dout_q;
    issued_we_d   = issued_we_q;
    cpu_grant_s   = 1'b0;
    ram_address_s = cpu_addr;
    ram_wren_s    = 1'b0;

    if (vid_req) begin
      ram_address_s = vid_addr;
      grant_d       = G_VID;
    end else if ((state_q == C_IDLE) && cpu_req) begin
      ram_address_s = cpu_addr;
      ram_wren_s    = cpu_we;
      grant_d       = G_CPU;
      cpu_grant_s   = 1'b1;
      issued_we_d   = cpu_we;
    end else begin
      ram_address_s = cpu_addr;
    end

    case (state_q)
      C_IDLE: begin
        if (cpu_grant_s) state_d = C_ISSUED;
        else             state_d = C_IDLE;
      end
      C_ISSUED: begin
        // ram_q carries the read result (or the written byte) this cycle
        state_d   = C_DONE;
        cpu_ack_d = 1'b1;
        if (!issued_we_q) cpu_dout_d = ram_q;
        else              cpu_dout_d = cpu_dout_q;
      end
      C_DONE: begin
        state_d = C_HOLD;
      end
      C_HOLD: begin
        if (!cpu_req) state_d = C_IDLE;
        else          state_d = C_HOLD;
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
  end

  // handshake and grant-tag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= C_IDLE;
      grant_q     <= G_NONE;
      cpu_ack_q   <= 1'b0;
      cpu_dout_q  <= {data_width_g{1'b0}};
      issued_we_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_dout_q  <= cpu_dout_d;
      issued_we_q <= issued_we_d;
    end
  end

  assign blocked_s = (state_q == C_IDLE) && cpu_req && vid_req;

  vram_starve_counter #(
    .width_g (starve_width_g)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .inc     (blocked_s),
    .clr     (cpu_grant_s),
    .starved (cpu_starved)
  );

  // wren is gated by reset directly so a write granted in the reset cycle never lands
  assign ram_wren    = ram_wren_s & ~reset;
  assign ram_address = ram_address_s;
  assign ram_data    = cpu_din;
  assign vid_valid   = (grant_q == G_VID);
  assign vid_dout    = ram_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_dout    = cpu_dout_q;
  assign cpu_wait    = cpu_req & ((state_q == C_IDLE) | (state_q == C_ISSUED));

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_vram_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int STARVE_MAX = (1 << SW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_dout;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic          cpu_wait;
  logic          cpu_starved;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q = 8'h00;

  int n_chk = 0;
  int n_err = 0;

  vram_port_arbiter #(
    .addr_width_g   (AW),
    .data_width_g   (DW),
    .starve_width_g (SW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_valid   (vid_valid),
    .vid_dout    (vid_dout),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .cpu_wait    (cpu_wait),
    .cpu_starved (cpu_starved),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  always #5 clock = ~clock;

  // Power-up contents of the VRAM (preload)
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 11'd37 + 11'd91;
    return t[7:0] ^ {5'd0, a[10:8]};
  endfunction

  // Behavioural single-port RAM: registered q, write data appears on q
  logic [2047:0] wr_val = '0;
  logic [DW-1:0] wr_dat [0:2047];
  always @(posedge clock) begin
    if (ram_wren) begin
      wr_val[ram_address] <= 1'b1;
      wr_dat[ram_address] <= ram_data;
      ram_q               <= ram_data;
    end else begin
      ram_q <= wr_val[ram_address] ? wr_dat[ram_address] : init_val(ram_address);
    end
  end

  // Reference model: memory image, cycles since CPU grant (-1 = none), etc.
  logic [DW-1:0] ref_mem [0:2047];
  int            m_age = -1;
  logic          m_we = 1'b0;
  logic [DW-1:0] m_rdata = 8'h00;
  logic [DW-1:0] m_dout = 8'h00;
  logic          m_vid_pend = 1'b0;
  logic [DW-1:0] m_vid_data = 8'h00;
  int            m_cnt = 0;
  logic          m_starved = 1'b0;
  logic          m_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, advances model, waits next edge
  task automatic tick();
    logic grant;
    #2;
    if (reset) begin
      m_age = -1; m_vid_pend = 1'b0; m_dout = 8'h00; m_cnt = 0; m_starved = 1'b0;
    end
    grant = !reset && !vid_req && (m_age < 0) && cpu_req;
    m_ack = (m_age == 2);
    check("ram_address", 32'(ram_address), vid_req ? 32'(vid_addr) : 32'(cpu_addr));
    check("ram_data",    32'(ram_data),    32'(cpu_din));
    check("ram_wren",    32'(ram_wren),    32'(grant && cpu_we));
    check("cpu_wait",    32'(cpu_wait),    32'(cpu_req && ((m_age < 0) || (m_age == 1))));
    check("cpu_ack",     32'(cpu_ack),     32'(m_ack));
    check("cpu_dout",    32'(cpu_dout),    32'(m_dout));
    check("vid_valid",   32'(vid_valid),   32'(m_vid_pend));
    if (m_vid_pend) check("vid_dout", 32'(vid_dout), 32'(m_vid_data));
    check("cpu_starved", 32'(cpu_starved), 32'(m_starved));
    if (!reset) begin
      m_vid_pend = vid_req;
      if (vid_req) m_vid_data = ref_mem[vid_addr];
      if ((m_age < 0) && cpu_req && vid_req) begin
        if (m_cnt < STARVE_MAX) m_cnt++;
        if (m_cnt == STARVE_MAX) m_starved = 1'b1;
      end
      if ((m_age == 1) && !m_we) m_dout = m_rdata;
      if (grant) begin
        m_age   = 1;
        m_cnt   = 0;
        m_we    = cpu_we;
        m_rdata = cpu_we ? cpu_din : ref_mem[cpu_addr];
        if (cpu_we) ref_mem[cpu_addr] = cpu_din;
      end else if ((m_age >= 1) && (m_age < 3)) begin
        m_age++;
      end else if ((m_age == 3) && !cpu_req) begin
        m_age = -1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic r, input logic vr, input logic [AW-1:0] va,
                     input logic cr, input logic cw, input logic [AW-1:0] ca,
                     input logic [DW-1:0] cd, input int n);
    reset = r; vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic          ag_req = 1'b0;
  logic          ag_we = 1'b0;
  logic [AW-1:0] ag_addr = '0;
  logic [DW-1:0] ag_din = '0;
  int            ag_gap = 1;
  int            ag_hold = -1;

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(11'(i));
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    @(posedge clock);
    #1;

    drv(1'b1, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 2);
    // write 0x123 <= 0xA5, then read it back
    drv(1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 11'h123, 8'hA5, 3);
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h123, 8'h00, 1);
    drv(1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 11'h123, 8'h3C, 3);
    check("wr_rd_dout", 32'(cpu_dout), 32'h0000_00A5);
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h123, 8'h00, 1);
    // video priority over a pending CPU read
    drv(1'b0, 1'b1, 11'h010, 1'b1, 1'b0, 11'h123, 8'h00, 3);
    drv(1'b0, 1'b0, 11'h010, 1'b1, 1'b0, 11'h123, 8'h00, 3);
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1);
    // request held 5 cycles past ack, then dropped one cycle and re-raised
    drv(1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 11'h200, 8'h5A, 8);
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h200, 8'h00, 1);
    drv(1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 11'h200, 8'h00, 3);
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1);
    // starvation: continuous video with CPU pending
    drv(1'b0, 1'b1, 11'h033, 1'b1, 1'b0, 11'h044, 8'h00, 10);
    drv(1'b0, 1'b0, 11'h033, 1'b1, 1'b0, 11'h044, 8'h00, 3);
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 2);
    check("starved_sticky", 32'(cpu_starved), 32'd1);
    // reset in the grant cycle of a write to 0x055
    drv(1'b1, 1'b0, 11'h000, 1'b1, 1'b1, 11'h055, 8'hFF, 1);
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h055, 8'h00, 1);
    drv(1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 11'h055, 8'h00, 3);
    check("rst_write_lost", 32'(cpu_dout), 32'(init_val(11'h055)));
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1);
    // back-to-back video over 0..7
    for (int n = 0; n < 8; n++) drv(1'b0, 1'b1, 11'(n), 1'b0, 1'b0, 11'h000, 8'h00, 1);
    drv(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 8'h00, 1);

    // randomized traffic with a protocol-following CPU agent
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 399) == 0);
      vid_req  = ($urandom_range(0, 9) < 4);
      vid_addr = 11'($urandom_range(0, 15));
      if (!ag_req) begin
        if (ag_gap > 0) begin
          ag_gap--;
        end else begin
          ag_req  = 1'b1;
          ag_we   = 1'($urandom_range(0, 1));
          ag_addr = 11'($urandom_range(0, 15));
          ag_din  = 8'($urandom);
          ag_hold = -1;
        end
      end
      cpu_req  = ag_req;
      cpu_we   = ag_we;
      cpu_addr = ag_addr;
      cpu_din  = ag_req ? ag_din : 8'($urandom);
      tick();
      if (reset) begin
        ag_req = 1'b0; ag_gap = 1; ag_hold = -1;
      end else if (ag_req) begin
        if (ag_hold < 0) begin
          if (m_ack) ag_hold = $urandom_range(0, 3);
        end else begin
          ag_hold--;
        end
        if (ag_hold == 0) begin
          ag_req = 1'b0; ag_gap = $urandom_range(1, 2); ag_hold = -1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Sits directly upstream of the single-port tile/colour VRAM instance. It muxes two requesters onto the RAM's one address/data/wren port.
- The video scanner has absolute priority. The Z80-side CPU bus is served in free cycles using a wait/ack handshake.
- Drives the RAM's address, data and wren. Consumes the RAM's registered q, which has 1-cycle read latency.
- Returns read data to each requester and flags CPU starvation for debug.

Parameters:
- addr_width_g, 11, VRAM address width
- data_width_g, 8, VRAM data width
- starve_width_g, 8, width of the CPU-starvation counter; threshold = 2**starve_width_g - 1

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- vid_req  in  1  video read request this cycle (single-cycle, no handshake)
- vid_addr  in  addr_width_g  video read address
- vid_valid  out  1  high the cycle after a video grant; vid_dout valid then
- vid_dout  out  data_width_g  wired from ram_q
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  addr_width_g  CPU address; stable while cpu_req high
- cpu_din  in  data_width_g  CPU write data
- cpu_dout  out  data_width_g  registered CPU read data; holds until next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  CPU wait/stall request
- cpu_starved  out  1  sticky starvation flag; cleared only by reset
- ram_address  out  addr_width_g  to RAM address
- ram_data  out  data_width_g  to RAM data
- ram_wren  out  1  to RAM wren
- ram_q  in  data_width_g  from RAM q

Behaviour:
- Reset: asynchronous and active-high.
  - Clears the CPU FSM to C_IDLE, vid_valid=0, cpu_ack=0, cpu_dout=0, cpu_starved=0, starve counter=0, grant tag=NONE.
  - ram_wren is forced 0 while reset is high (combinational gating).
  - RAM contents are not touched.
- CPU FSM states:
  - C_IDLE: waiting for a request.
  - C_ISSUED: grant was given last cycle; ram_q/write completes this cycle.
  - C_DONE: cpu_ack=1 for exactly this cycle.
  - C_HOLD: waiting for cpu_req to drop.
- Grant mux (combinational, each cycle):
  - If vid_req=1: ram_address=vid_addr, ram_wren=0. This is a video grant.
  - Else if state=C_IDLE and cpu_req=1: ram_address=cpu_addr, ram_data=cpu_din, ram_wren=cpu_we. This is a CPU grant; next state is C_ISSUED.
  - Else: ram_address=cpu_addr, ram_wren=0. This is an idle cycle.
  - ram_data is always cpu_din.
- Transitions:
  - C_ISSUED -> C_DONE, unconditionally. On a read, cpu_dout<=ram_q at the end of C_ISSUED.
  - C_DONE -> C_HOLD.
  - C_HOLD -> C_IDLE when cpu_req=0.
  - A new CPU request therefore requires cpu_req low for at least 1 cycle.
- Latency:
  - CPU with no video contention: grant in cycle G, cpu_ack in G+2. Reads and writes are identical.
  - Video: vid_valid registered, high in G+1; vid_dout=ram_q in that cycle.
- cpu_wait = cpu_req AND state in {C_IDLE, C_ISSUED}. It falls in the cycle cpu_ack rises.
- Starvation:
  - The counter increments each cycle state=C_IDLE, cpu_req=1 and vid_req=1. It clears on any CPU grant and saturates.
  - When it reaches 2**starve_width_g - 1, cpu_starved<=1 (sticky).
  - Video priority is never overridden.
- Simultaneous events:
  - vid_req and a CPU request in the same cycle: video wins, the CPU stays in C_IDLE, and cpu_wait stays high.
  - vid_req during C_ISSUED/C_DONE/C_HOLD needs no arbitration; the CPU does not own the port in those states.
- A write-then-read to the same address reads the new value, because the RAM returns write data on q in a write cycle.
- Reset mid-operation:
  - A pending CPU access is abandoned with no cpu_ack. The CPU must re-request after reset.
  - A write granted in the reset cycle is suppressed.

Decomposition:
- Shared package holds:
  - CPU FSM state encoding (C_IDLE=0, C_ISSUED=1, C_DONE=2, C_HOLD=3).
  - Grant tag enum (NONE, VID, CPU).
  - Default width constants (11, 8, 8).
- Optional sub-module: vram_starve_counter (saturating counter plus sticky flag). Everything else stays in one module.

Test Plan:
- CPU write with no video: cpu_req=1, cpu_we=1, addr=0x123, din=0xA5 at cycle 0.
  - ram_wren=1 with ram_address=0x123 in cycle 0.
  - cpu_ack in cycle 2; cpu_wait high in cycles 0-1.
  - Then a CPU read of 0x123 returns cpu_dout=0xA5 at its ack.
- Video priority: vid_req=1 with vid_addr=0x010 in cycles 0-2, CPU read of 0x123 pending from cycle 0.
  - vid_valid high in cycles 1-3, with vid_dout matching preloaded data.
  - CPU granted in cycle 3, ack in cycle 5.
  - ram_wren=0 throughout.
- Handshake hold: keep cpu_req high for 5 cycles after ack.
  - No second grant and no second ack.
  - Drop req for 1 cycle, re-raise: new grant the same cycle as re-raise.
- Starvation (starve_width_g=3): vid_req=1 continuously with CPU pending.
  - cpu_starved rises after 7 blocked cycles.
  - It stays 1 after vid_req drops and the CPU completes.
- Reset mid-op: assert reset in the CPU write grant cycle (addr 0x055, data 0xFF).
  - ram_wren=0, no cpu_ack; all outputs return to reset values immediately.
  - A later read of 0x055 shows the old value.
- Back-to-back video: vid_req every cycle over addr 0..7.
  - vid_valid is continuous from cycle 1 to 8.
  - vid_dout equals preload[n] in cycle n+1.
